// File: rtl/cim_psum_accumulator.sv
// Accumulates NUM_TILES adder-tree partial sums plus a signed bias, then applies ReLU,
// right-shift requantisation and unsigned saturation. Optional macro CIM_ROUND_EN selects round-half-up.
module cim_psum_accumulator #(
    parameter int unsigned NUM_TILES = 4,
    parameter int unsigned PSUM_W    = 13,
    parameter int unsigned BIAS_W    = 16,
    parameter int unsigned ACC_W     = 18,
    parameter int unsigned SHIFT     = 7,
    parameter int unsigned OUT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bias_load,
    input  logic [BIAS_W-1:0] bias_in,
    input  logic              input_valid,
    input  logic [PSUM_W-1:0] Psum,
    output logic              busy,
    output logic              out_valid,
    output logic [OUT_W-1:0]  Output
);

    localparam int unsigned CNT_W  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int unsigned Q_W    = ACC_W + 1;
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [Q_W-1:0] OUT_MAX = Q_W'((64'(1) << OUT_W) - 64'(1));
`ifdef CIM_ROUND_EN
    localparam logic [Q_W-1:0] RND = (SHIFT > 0) ? (Q_W'(1) << RND_SH) : '0;
`else
    localparam logic [Q_W-1:0] RND = '0;
`endif

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIAS_W-1:0]  bias_q, bias_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   output_q, output_d;
    logic               busy_q, busy_d;

    logic [ACC_W-1:0]   psum_ext_c;
    logic [ACC_W-1:0]   bias_ext_c;
    logic [ACC_W-1:0]   v_c;
    logic [Q_W-1:0]     q_c;
    logic [OUT_W-1:0]   act_c;

    // ReLU, optional rounding offset, shift and saturation of the final sum
    always_comb begin
        psum_ext_c = {{(ACC_W-PSUM_W){1'b0}}, Psum};
        bias_ext_c = {{(ACC_W-BIAS_W){bias_d[BIAS_W-1]}}, bias_d};
        v_c        = (state_q == IDLE) ? (bias_ext_c + psum_ext_c) : (acc_q + psum_ext_c);
        q_c        = ({1'b0, v_c} + RND) >> SHIFT;
        if (v_c[ACC_W-1] || (v_c == '0)) begin
            act_c = '0;
        end else if (q_c > OUT_MAX) begin
            act_c = '1;
        end else begin
            act_c = q_c[OUT_W-1:0];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bias_d      = bias_load ? bias_in : bias_q;
        out_valid_d = 1'b0;
        output_d    = output_q;
        if (input_valid) begin
            if ((state_q == IDLE && NUM_TILES == 1) ||
                (state_q == ACC && cnt_q == CNT_W'(NUM_TILES - 1))) begin
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                output_d    = act_c;
            end else begin
                state_d = ACC;
                acc_d   = v_c;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
        busy_d = (state_d == ACC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            output_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            output_q    <= output_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign Output    = output_q;

endmodule

// File: tb/tb_cim_psum_accumulator.sv
// Scoreboard bench for cim_psum_accumulator: directed scenarios then randomized traffic.
module tb_cim_psum_accumulator;

    localparam int N  = 4;
    localparam int PW = 13;
    localparam int BW = 16;
    localparam int SH = 7;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          bias_load;
    logic [BW-1:0] bias_in;
    logic          input_valid;
    logic [PW-1:0] Psum;
    logic          busy;
    logic          out_valid;
    logic [OW-1:0] Output;

    cim_psum_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .bias_load  (bias_load),
        .bias_in    (bias_in),
        .input_valid(input_valid),
        .Psum       (Psum),
        .busy       (busy),
        .out_valid  (out_valid),
        .Output     (Output)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int val;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    // Reference model: list of psums in the open group plus the bias captured at its start
    int     grp[$];
    longint grp_bias;
    longint m_bias;

    function automatic int post(longint v);
        longint q;
        if (v <= 0) return 0;
`ifdef CIM_ROUND_EN
        q = (v + longint'(2 ** (SH - 1))) / longint'(2 ** SH);
`else
        q = v / longint'(2 ** SH);
`endif
        if (q > longint'(2 ** OW - 1)) return 2 ** OW - 1;
        return int'(q);
    endfunction

    task automatic step(input bit r, input bit v, input int p, input bit bl, input int bi);
        longint sum;
        exp_t   e;
        @(negedge clk);
        rst         = r;
        input_valid = v;
        Psum        = PW'(p);
        bias_load   = bl;
        bias_in     = BW'(bi);
        if (r) begin
            grp.delete();
            m_bias = 0;
        end else begin
            if (bl) m_bias = longint'(bi);
            if (v) begin
                if (grp.size() == 0) grp_bias = m_bias;
                grp.push_back(p);
                if (grp.size() == N) begin
                    sum = grp_bias;
                    foreach (grp[i]) sum += longint'(grp[i]);
                    e.val = post(sum);
                    e.cyc = cyc + 1;
                    sbq.push_back(e);
                    grp.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== (grp.size() != 0)) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, grp.size() != 0);
        end
        if (r) begin
            checks++;
            if (out_valid !== 1'b0 || Output !== '0) begin
                errors++;
                $display("FAIL reset_outputs got out_valid=%b Output=%0d exp 0/0", out_valid, Output);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: every out_valid pulse must match the oldest predicted result, value and cycle
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d Output=%0d", cyc, Output);
            end else begin
                e = sbq.pop_front();
                if (Output !== OW'(e.val) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL output cyc=%0d got=%0d exp=%0d at cyc %0d", cyc, Output, e.val, e.cyc);
                end
            end
        end
    end

    initial begin
        int r, v, p, bl, bi;
        rst = 1'b1; input_valid = 1'b0; Psum = '0; bias_load = 1'b0; bias_in = '0;
        grp_bias = 0; m_bias = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(2);

        // 1: bias 0, four psums of 50
        for (int i = 0; i < 4; i++) step(0, 1, 50, 0, 0);
        idle(2);
        // 2: saturation with bias 1000
        step(0, 0, 0, 1, 1000);
        for (int i = 0; i < 4; i++) step(0, 1, 8191, 0, 0);
        idle(2);
        // 3: negative bias loaded with first psum -> ReLU
        step(0, 1, 1000, 1, -20000);
        for (int i = 0; i < 3; i++) step(0, 1, 1000, 0, 0);
        idle(2);
        // 4: gapped group then back-to-back group
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 128, 0, 0);
            if (i < 3) idle(2);
        end
        for (int i = 0; i < 4; i++) step(0, 1, 256, 0, 0);
        idle(2);
        // 5: mid-group reset
        step(0, 1, 1000, 0, 0);
        step(0, 1, 1000, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 128, 0, 0);
        idle(2);
        // 6: bias change mid-group applies to the next group only
        step(0, 1, 128, 0, 0);
        step(0, 1, 128, 0, 0);
        step(0, 1, 128, 1, 640);
        step(0, 1, 128, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 128, 0, 0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 79) == 0) ? 1 : 0;
            v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            p  = ($urandom_range(0, 3) == 0) ? $urandom_range(7000, 8191) : $urandom_range(0, 8191);
            bl = ($urandom_range(0, 9) == 0) ? 1 : 0;
            bi = $urandom_range(0, 65535) - 32768;
            step(r[0], v[0], p, bl[0], bi);
        end
        idle(4);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses got=0 exp=%0d outstanding", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
